// File: rtl/ibex_req_arb2.sv
// rtl/ibex_req_arb2.sv - two-host arbiter sharing one Ibex-style req/gnt/rvalid port
//
// Shares one single-outstanding req/gnt/rvalid port between hosts h0 and h1.
// The selected host's request is held stable until granted, and the response
// is routed back to the owner. If no response arrives within TIMEOUT_CYCLES
// of the grant, an error response is synthesized and the late response is
// discarded later.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   hN_req/we/be/addr/wdata_i          host N request channel (N = 0,1)
//   hN_gnt/rvalid/rdata/err_o          host N grant and response
//   req/we/be/addr/wdata_o, gnt_i      shared-port request channel
//   rvalid_i, rdata_i, err_i           shared-port response
//   timeout_o                          1-cycle pulse on a synthesized timeout
module ibex_req_arb2 #(
    parameter logic        PRIO_FIXED     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        h0_req_i,
    input  logic        h0_we_i,
    input  logic [3:0]  h0_be_i,
    input  logic [31:0] h0_addr_i,
    input  logic [31:0] h0_wdata_i,
    output logic        h0_gnt_o,
    output logic        h0_rvalid_o,
    output logic [31:0] h0_rdata_o,
    output logic        h0_err_o,
    input  logic        h1_req_i,
    input  logic        h1_we_i,
    input  logic [3:0]  h1_be_i,
    input  logic [31:0] h1_addr_i,
    input  logic [31:0] h1_wdata_i,
    output logic        h1_gnt_o,
    output logic        h1_rvalid_o,
    output logic [31:0] h1_rdata_o,
    output logic        h1_err_o,
    output logic        req_o,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    input  logic        err_i,
    output logic        timeout_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          sel_q, lock_q, owner_q, last_q;
    logic [CW-1:0] cnt_q;
    logic          sel, sel_req, timeout_hit;

    // A lock only holds while the locked host still requests; if it withdraws,
    // arbitration is free again in the same cycle.
    always_comb begin
        if (lock_q && (sel_q ? h1_req_i : h0_req_i)) begin
            sel = sel_q;
        end else if (h0_req_i && !h1_req_i) begin
            sel = 1'b0;
        end else if (h1_req_i && !h0_req_i) begin
            sel = 1'b1;
        end else if (PRIO_FIXED) begin
            sel = 1'b0;
        end else begin
            sel = ~last_q;
        end
    end

    assign sel_req = sel ? h1_req_i : h0_req_i;

    // A real response arriving on the timeout cycle takes precedence.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !rvalid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (sel_req && gnt_i) state_d = WAIT_RSP;
            WAIT_RSP: begin
                if (rvalid_i) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:    if (rvalid_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q   <= 1'b0;
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_req && gnt_i) begin
                        owner_q <= sel;
                        last_q  <= sel;
                        lock_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (sel_req) begin
                        lock_q  <= 1'b1;
                        sel_q   <= sel;
                    end else begin
                        lock_q  <= 1'b0;
                    end
                end
                WAIT_RSP: cnt_q <= cnt_q + CW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        req_o       = 1'b0;
        we_o        = 1'b0;
        be_o        = '0;
        addr_o      = '0;
        wdata_o     = '0;
        h0_gnt_o    = 1'b0;
        h1_gnt_o    = 1'b0;
        h0_rvalid_o = 1'b0;
        h1_rvalid_o = 1'b0;
        h0_rdata_o  = '0;
        h1_rdata_o  = '0;
        h0_err_o    = 1'b0;
        h1_err_o    = 1'b0;
        timeout_o   = 1'b0;
        case (state_q)
            IDLE: begin
                // Fields are gated by the request so the port stays all-zero when idle.
                if (sel_req) begin
                    req_o   = 1'b1;
                    we_o    = sel ? h1_we_i    : h0_we_i;
                    be_o    = sel ? h1_be_i    : h0_be_i;
                    addr_o  = sel ? h1_addr_i  : h0_addr_i;
                    wdata_o = sel ? h1_wdata_i : h0_wdata_i;
                end
                h0_gnt_o = !sel && req_o && gnt_i;
                h1_gnt_o =  sel && req_o && gnt_i;
            end
            WAIT_RSP: begin
                if (rvalid_i) begin
                    if (owner_q) begin
                        h1_rvalid_o = 1'b1;
                        h1_rdata_o  = rdata_i;
                        h1_err_o    = err_i;
                    end else begin
                        h0_rvalid_o = 1'b1;
                        h0_rdata_o  = rdata_i;
                        h0_err_o    = err_i;
                    end
                end else if (timeout_hit) begin
                    timeout_o = 1'b1;
                    if (owner_q) begin
                        h1_rvalid_o = 1'b1;
                        h1_err_o    = 1'b1;
                    end else begin
                        h0_rvalid_o = 1'b1;
                        h0_err_o    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ibex_req_arb2.sv
// tb/tb_ibex_req_arb2.sv - directed self-checking bench for ibex_req_arb2
module tb_ibex_req_arb2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        h0_req, h0_we, h1_req, h1_we;
    logic [3:0]  h0_be, h1_be;
    logic [31:0] h0_addr, h0_wdata, h1_addr, h1_wdata;
    logic        gnt_i, rvalid_i, err_i;
    logic [31:0] rdata_i;

    logic        h0_gnt, h0_rvalid, h0_err, h1_gnt, h1_rvalid, h1_err;
    logic [31:0] h0_rdata, h1_rdata;
    logic        req_o, we_o, timeout_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o, wdata_o;

    logic        f_h0_gnt, f_h0_rvalid, f_h0_err, f_h1_gnt, f_h1_rvalid, f_h1_err;
    logic [31:0] f_h0_rdata, f_h1_rdata;
    logic        f_req_o, f_we_o, f_timeout_o;
    logic [3:0]  f_be_o;
    logic [31:0] f_addr_o, f_wdata_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    ibex_req_arb2 #(.PRIO_FIXED(1'b0), .TIMEOUT_CYCLES(8)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr), .h0_wdata_i(h0_wdata),
        .h0_gnt_o(h0_gnt), .h0_rvalid_o(h0_rvalid), .h0_rdata_o(h0_rdata), .h0_err_o(h0_err),
        .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr), .h1_wdata_i(h1_wdata),
        .h1_gnt_o(h1_gnt), .h1_rvalid_o(h1_rvalid), .h1_rdata_o(h1_rdata), .h1_err_o(h1_err),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i), .timeout_o(timeout_o)
    );

    ibex_req_arb2 #(.PRIO_FIXED(1'b1), .TIMEOUT_CYCLES(0)) u_dut_fix (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr), .h0_wdata_i(h0_wdata),
        .h0_gnt_o(f_h0_gnt), .h0_rvalid_o(f_h0_rvalid), .h0_rdata_o(f_h0_rdata), .h0_err_o(f_h0_err),
        .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr), .h1_wdata_i(h1_wdata),
        .h1_gnt_o(f_h1_gnt), .h1_rvalid_o(f_h1_rvalid), .h1_rdata_o(f_h1_rdata), .h1_err_o(f_h1_err),
        .req_o(f_req_o), .we_o(f_we_o), .be_o(f_be_o), .addr_o(f_addr_o), .wdata_o(f_wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i), .timeout_o(f_timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, h0_rdata | h1_rdata | addr_o | wdata_o, 32'h0);
        check({tag, "_ctl"}, {22'h0, h0_gnt, h0_rvalid, h0_err, h1_gnt, h1_rvalid, h1_err,
                              req_o, we_o, |be_o, timeout_o}, 32'h0);
    endtask

    initial begin
        rst_ni   = 1'b0;
        h0_req   = 1'b0; h0_we = 1'b0; h0_be = 4'h0; h0_addr = '0; h0_wdata = '0;
        h1_req   = 1'b0; h1_we = 1'b0; h1_be = 4'h0; h1_addr = '0; h1_wdata = '0;
        gnt_i    = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;

        #2;
        check_all_zero("in_reset");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        check_all_zero("after_reset");

        // 1: h0 read 0x1000, granted at once, response two cycles later
        h0_req = 1'b1; h0_addr = 32'h1000; h0_be = 4'hF; gnt_i = 1'b1;
        #1;
        check("t1_req", {31'h0, req_o}, 32'h1);
        check("t1_addr", addr_o, 32'h1000);
        check("t1_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h1);
        cyc();
        h0_req = 1'b0; gnt_i = 1'b0;
        check("t1_wait", {29'h0, req_o, h0_gnt, h0_rvalid}, 32'h0);
        cyc();
        rvalid_i = 1'b1; rdata_i = 32'hDEADBEEF;
        #1;
        check("t1_rvalid", {31'h0, h0_rvalid}, 32'h1);
        check("t1_rdata", h0_rdata, 32'hDEADBEEF);
        check("t1_h1_quiet", {29'h0, h1_gnt, h1_rvalid, h1_err} | h1_rdata, 32'h0);
        cyc();
        rvalid_i = 1'b0;
        check("t1_done", {31'h0, h0_rvalid}, 32'h0);

        // 2: both hosts request; h0 won last, so round-robin goes h1,h0,h1; fixed prio h0 only
        h0_req = 1'b1; h0_addr = 32'h2000; h1_req = 1'b1; h1_addr = 32'h3000; gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rvalid_i = 1'b0;
            #1;
            check("t2_gnt_rr", {30'h0, h1_gnt, h0_gnt}, (i % 2 == 0) ? 32'h2 : 32'h1);
            check("t2_gnt_fix", {30'h0, f_h1_gnt, f_h0_gnt}, 32'h1);
            cyc();
            rvalid_i = 1'b1; rdata_i = 32'h100 + i;
            #1;
            check("t2_rsp_rr", {30'h0, h1_rvalid, h0_rvalid}, (i % 2 == 0) ? 32'h2 : 32'h1);
            check("t2_rsp_fix", {30'h0, f_h1_rvalid, f_h0_rvalid}, 32'h1);
            check("t2_no_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h0);
            cyc();
        end
        rvalid_i = 1'b0;

        // 3: both request, grant stalled 3 cycles while h1 changes its address
        gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            h1_addr = 32'h3000 + 32'(i * 4);
            #1;
            check("t3_addr_hold", addr_o, 32'h2000);
            check("t3_no_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h0);
            cyc();
        end
        gnt_i = 1'b1;
        #1;
        check("t3_addr_gnt", addr_o, 32'h2000);
        check("t3_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h1);
        cyc();
        h0_req = 1'b0; h1_req = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1;
        #1;
        check("t3_rsp", {30'h0, h1_rvalid, h0_rvalid}, 32'h1);
        cyc();
        rvalid_i = 1'b0;

        // 3b: lock keeps h0 even when h1 joins and round-robin would favour h1
        h0_req = 1'b1; h0_addr = 32'h4000;
        #1;
        check("t3b_first", addr_o, 32'h4000);
        cyc();
        h1_req = 1'b1;
        #1;
        check("t3b_locked", addr_o, 32'h4000);
        cyc();
        gnt_i = 1'b1;
        #1;
        check("t3b_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h1);
        cyc();
        h0_req = 1'b0; h1_req = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1;
        cyc();
        rvalid_i = 1'b0;

        // 4: timeout 8 cycles after grant, late response at +12 dropped
        h1_req = 1'b1; h1_addr = 32'h5000; gnt_i = 1'b1;
        #1;
        check("t4_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h2);
        cyc();
        h1_req = 1'b0; gnt_i = 1'b0; rdata_i = 32'hCAFEF00D;
        for (int i = 1; i < 8; i++) begin
            #1;
            check("t4_pre_to", {30'h0, h1_rvalid, timeout_o}, 32'h0);
            cyc();
        end
        #1;
        check("t4_to_rvalid", {30'h0, h1_rvalid, h1_err}, 32'h3);
        check("t4_to_rdata", h1_rdata, 32'h0);
        check("t4_to_pulse", {30'h0, timeout_o, h0_rvalid}, 32'h2);
        cyc();
        h0_req = 1'b1; h0_addr = 32'h6000; gnt_i = 1'b1;
        for (int i = 9; i < 12; i++) begin
            #1;
            check("t4_drain", {29'h0, req_o, h0_gnt, timeout_o}, 32'h0);
            cyc();
        end
        rvalid_i = 1'b1; rdata_i = 32'h11111111;
        #1;
        check("t4_late_drop", {29'h0, h0_rvalid, h1_rvalid, h0_gnt}, 32'h0);
        cyc();
        rvalid_i = 1'b0;
        #1;
        check("t4_next_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h1);
        cyc();
        h0_req = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1;
        #1;
        check("t4_next_rsp", {31'h0, h0_rvalid}, 32'h1);
        cyc();
        rvalid_i = 1'b0;

        // 5: response lands exactly on the timeout cycle
        h0_req = 1'b1; gnt_i = 1'b1;
        #1;
        check("t5_gnt", {31'h0, h0_gnt}, 32'h1);
        cyc();
        h0_req = 1'b0; gnt_i = 1'b0;
        repeat (7) cyc();
        rvalid_i = 1'b1; err_i = 1'b0; rdata_i = 32'hA5A5A5A5;
        #1;
        check("t5_rvalid", {29'h0, h0_rvalid, h0_err, timeout_o}, 32'h4);
        check("t5_rdata", h0_rdata, 32'hA5A5A5A5);
        cyc();
        rvalid_i = 1'b0; h1_req = 1'b1; h1_addr = 32'h7000; gnt_i = 1'b1;
        #1;
        check("t5_idle_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h2);
        cyc();
        h1_req = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1;
        cyc();
        rvalid_i = 1'b0;

        // 6: reset while waiting for a response, then a stray response
        h0_req = 1'b1; gnt_i = 1'b1;
        #1;
        check("t6_gnt", {31'h0, h0_gnt}, 32'h1);
        cyc();
        h0_req = 1'b0; gnt_i = 1'b0; rst_ni = 1'b0;
        #1;
        check_all_zero("t6_rst");
        cyc();
        cyc();
        rst_ni = 1'b1; rvalid_i = 1'b1; rdata_i = 32'h00000BAD;
        #1;
        check("t6_stray", {29'h0, h0_rvalid, h1_rvalid, timeout_o} | h0_rdata | h1_rdata, 32'h0);
        cyc();
        rvalid_i = 1'b0; h1_req = 1'b1; h1_addr = 32'h8000; gnt_i = 1'b1;
        #1;
        check("t6_h1_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h2);
        check("t6_h1_addr", addr_o, 32'h8000);
        cyc();
        h1_req = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h5555;
        #1;
        check("t6_h1_rsp", {31'h0, h1_rvalid}, 32'h1);
        check("t6_h1_rdata", h1_rdata, 32'h5555);
        cyc();
        rvalid_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed no end of run, expected finish before 50000");
        $fatal(1, "watchdog expired");
    end

endmodule
